// File: rtl/seqgen_pkg.sv
// rtl/seqgen_pkg.sv - shared state encodings and length saturation for the pattern sequence generator
package seqgen_pkg;

    // 2'b11 is deliberately left unnamed: it is the illegal encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] STATE_ILLEGAL = 2'b11;

    // A requested length of zero or one beyond the register width means
    // "send the whole pattern".
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned pat_w);
        if ((len == 0) || (len > pat_w)) begin
            return pat_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/seqgen_shreg.sv
// rtl/seqgen_shreg.sv - left-justified load/shift register with bit down-counter and reload copy
module seqgen_shreg
    import seqgen_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             reload,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             msb,
    output logic             last
);

    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] pat_latch;
    logic [LEN_W-1:0] len_latch;
    logic [LEN_W-1:0] cnt;

    // Load captures both the working copy and a pristine copy so a repeat can
    // restart the pattern without going back through IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg     <= '0;
            pat_latch <= '0;
            len_latch <= '0;
            cnt       <= '0;
        end else if (load) begin
            shreg     <= pattern;
            pat_latch <= pattern;
            len_latch <= len;
            cnt       <= len;
        end else if (reload) begin
            shreg     <= pat_latch;
            cnt       <= len_latch;
        end else if (shift) begin
            shreg     <= {shreg[PAT_W-2:0], 1'b0};
            cnt       <= cnt - LEN_W'(1);
        end
    end

    // The bit currently on the line is always the top of the register.
    always_comb begin
        msb  = shreg[PAT_W-1];
        last = (cnt == LEN_W'(1));
    end

endmodule

// File: rtl/tt_um_marxkar_seqgen.sv
// rtl/tt_um_marxkar_seqgen.sv - serial pattern generator FSM top (optional SEQGEN_REPEAT_EN adds repeat_req)
module tt_um_marxkar_seqgen
    import seqgen_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SEQGEN_REPEAT_EN
    input  logic             repeat_req,
`endif
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       present_state
);

    state_t           state;
    state_t           state_next;
    logic             rep;
    logic             load;
    logic             shift;
    logic             reload;
    logic             msb;
    logic             last;
    logic [LEN_W-1:0] len_sat;

`ifdef SEQGEN_REPEAT_EN
    assign rep = repeat_req;
`else
    assign rep = 1'b0;
`endif

    assign len_sat = LEN_W'(eff_len(32'(len), PAT_W));

    // Datapath strobes: start is only honoured in IDLE, so pattern/len
    // changes during a transfer never reach the register.
    always_comb begin
        load   = (state == IDLE) && start;
        shift  = (state == SEND);
        reload = (state == SEND) && last && rep;
    end

    seqgen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .reload  (reload),
        .pattern (pattern),
        .len     (len_sat),
        .msb     (msb),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? SEND : IDLE;
            SEND:    state_next = last ? (rep ? SEND : DONE) : SEND;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; serial_out is gated so it is zero whenever no bit is valid.
    always_comb begin
        serial_out    = 1'b0;
        bit_valid     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        present_state = state;
        case (state)
            SEND: begin
                serial_out = msb;
                bit_valid  = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            IDLE: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tt_um_marxkar_seqgen.sv
// tb/tb_tt_um_marxkar_seqgen.sv - scoreboard bench for the serial pattern generator
module tb_tt_um_marxkar_seqgen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
`ifdef SEQGEN_REPEAT_EN
    logic       repeat_req = 1'b0;
`endif
    logic       serial_out;
    logic       bit_valid;
    logic       busy;
    logic       done;
    logic [1:0] present_state;

    tt_um_marxkar_seqgen #(.PAT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef SEQGEN_REPEAT_EN
        .repeat_req    (repeat_req),
`endif
        .start         (start),
        .pattern       (pattern),
        .len           (len),
        .serial_out    (serial_out),
        .bit_valid     (bit_valid),
        .busy          (busy),
        .done          (done),
        .present_state (present_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle with a valid bit or done pulse consumes one expected item.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bit_valid === 1'b1 || done === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output at cycle %0d: valid=%b done=%b bit=%b, expected nothing",
                             cyc, bit_valid, done, serial_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || done !== mon_e.is_done || bit_valid !== !mon_e.is_done
                        || serial_out !== mon_e.val) begin
                        n_bad++;
                        $display("FAIL stream at cycle %0d: valid=%b done=%b bit=%b, expected cycle %0d done=%b bit=%b",
                                 cyc, bit_valid, done, serial_out, mon_e.cyc, mon_e.is_done, mon_e.val);
                    end
                end
            end else begin
                check("serial_idle_zero", {31'd0, serial_out}, 32'd0);
            end
        end
    end

    task automatic push_bits(input int s, input logic [7:0] pat, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.cyc = s + 1 + i;
            e.is_done = 1'b0;
            e.val = pat[7-i];
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input int c);
        exp_t e;
        e.cyc = c;
        e.is_done = 1'b1;
        e.val = 1'b0;
        exp_q.push_back(e);
    endtask

    // One complete transfer; n is the hand-computed effective length.
    task automatic xfer(input logic [7:0] pat, input logic [3:0] l, input int n);
        int s;
        @(negedge clk);
        s = cyc;
        pattern = pat;
        len = l;
        start = 1'b1;
        push_bits(s, pat, n);
        push_done(s + n + 1);
        @(negedge clk);
        start = 1'b0;
        check("state_send", present_state, 32'd1);
        check("busy_send", busy, 32'd1);
        repeat (n) @(negedge clk);
        check("state_done", present_state, 32'd2);
        @(negedge clk);
        check("state_idle_after", present_state, 32'd0);
        check("busy_idle", busy, 32'd0);
    endtask

    initial begin
        int s;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial", serial_out, 32'd0);
        check("rst_valid", bit_valid, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_state", present_state, 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        xfer(8'b1011_0010, 4'd8, 8);
        xfer(8'b1100_0000, 4'd3, 3);
        xfer(8'b1100_0000, 4'd0, 8);
        xfer(8'h5A, 4'd9, 8);
        xfer(8'h80, 4'd1, 1);
        xfer(8'b0110_1001, 4'd5, 5);

        // start and a new pattern mid-transfer must be ignored
        @(negedge clk);
        s = cyc;
        pattern = 8'b1011_0010;
        len = 4'd8;
        start = 1'b1;
        push_bits(s, 8'b1011_0010, 8);
        push_done(s + 9);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        pattern = 8'hFF;
        len = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignore_start_idle", present_state, 32'd0);
        repeat (4) @(negedge clk);

        // start held high: exactly one idle cycle between DONE and next first bit
        @(negedge clk);
        s = cyc;
        pattern = 8'hC3;
        len = 4'd2;
        start = 1'b1;
        push_bits(s, 8'hC3, 2);
        push_done(s + 3);
        push_bits(s + 4, 8'hC3, 2);
        push_done(s + 7);
        repeat (4) @(negedge clk);
        check("b2b_idle_gap", present_state, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_send", present_state, 32'd1);
        repeat (3) @(negedge clk);
        check("b2b_end_idle", present_state, 32'd0);

        // reset in the middle of a transfer aborts without done
        @(negedge clk);
        s = cyc;
        pattern = 8'b1011_0010;
        len = 4'd8;
        start = 1'b1;
        push_bits(s, 8'b1011_0010, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_serial", serial_out, 32'd0);
        check("abort_valid", bit_valid, 32'd0);
        check("abort_busy", busy, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_state", present_state, 32'd0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_stays_idle", present_state, 32'd0);

`ifdef SEQGEN_REPEAT_EN
        // three passes of a 4-bit pattern with no gap and a single done
        @(negedge clk);
        s = cyc;
        pattern = 8'b1010_0110;
        len = 4'd4;
        repeat_req = 1'b1;
        start = 1'b1;
        push_bits(s, 8'b1010_0110, 4);
        push_bits(s + 4, 8'b1010_0110, 4);
        push_bits(s + 8, 8'b1010_0110, 4);
        push_done(s + 13);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        repeat_req = 1'b0;
        repeat (4) @(negedge clk);
        check("repeat_done_state", present_state, 32'd2);
        repeat (4) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_um_marxkar_seqgen.md
TT_UM_MARXKAR_SEQGEN -- requirements
Module: tt_um_marxkar_seqgen

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits (2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to transmit the pattern; sampled only in IDLE.
REQ-005 SHALL have port pattern  input  PAT_W  bits to send, MSB-first; captured on accepted start.
REQ-006 SHALL have port len  input  $clog2(PAT_W)+1  number of bits to send; captured on accepted start.
REQ-007 SHALL have port serial_out  output  1  registered serial bit stream.
REQ-008 SHALL have port bit_valid  output  1  high while serial_out carries a pattern bit.
REQ-009 SHALL have port busy  output  1  high in SEND and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last bit.
REQ-011 SHALL have port present_state  output  2  current FSM state encoding, for debug and lock-step checking.

Function
REQ-012 SHALL implement states IDLE=2'b00, SEND=2'b01, DONE=2'b10; 2'b11 illegal, SHALL go to IDLE next cycle with all outputs low.
REQ-013 IDLE: start=1 SHALL latch pattern and effective length, load the bit counter and enter SEND next cycle.
REQ-014 Effective length SHALL be len when 1 <= len <= PAT_W; len=0 or len>PAT_W SHALL be treated as PAT_W.
REQ-015 Latched pattern SHALL be left-justified so bit (PAT_W-1) goes first; first bit on serial_out the cycle after start is sampled (latency 1).
REQ-016 SEND SHALL present one bit per cycle with bit_valid=1 for exactly effective-length consecutive cycles.
REQ-017 After the last bit SHALL enter DONE for one cycle: done=1, bit_valid=0, serial_out=0, then IDLE.
REQ-018 serial_out SHALL be 0 whenever bit_valid=0.
REQ-019 start SHALL be ignored in SEND and DONE; pattern/len changes during SEND SHALL not affect the transfer.
REQ-020 Back-to-back: start held high SHALL begin the next transfer from IDLE, giving exactly one idle cycle between DONE and the next first bit.

Reset
REQ-021 reset=0 at a rising edge SHALL force IDLE, serial_out=0, bit_valid=0, busy=0, done=0, present_state=2'b00, clear counter and latched pattern.
REQ-022 Reset mid-SEND SHALL abort with no done pulse; first transfer after release requires a fresh start.

Configuration
REQ-023 Macro SEQGEN_REPEAT_EN SHALL add input repeat (1 bit).
REQ-024 With SEQGEN_REPEAT_EN: repeat=1 in the last SEND cycle SHALL reload the latched pattern and continue with no gap and no done pulse; repeat=0 there SHALL proceed to DONE as normal.
REQ-025 Without SEQGEN_REPEAT_EN: no repeat port; behaviour exactly REQ-012..REQ-020.

Structure
REQ-026 Package seqgen_pkg SHALL hold the state typedef/encodings (IDLE, SEND, DONE) and the length-saturation function.
REQ-027 Sub-module seqgen_shreg SHALL hold the PAT_W-bit load/shift register and down-counter; FSM stays in the top.

Verification
REQ-028 pattern=8'b1011_0010, len=8, start 1 cycle -> serial_out 1,0,1,1,0,0,1,0 on cycles 1..8 with bit_valid=1, done=1 cycle 9, IDLE cycle 10.
REQ-029 pattern=8'b1100_0000, len=3 -> bits 1,1,0 on cycles 1..3, done cycle 4; len=0 -> 8 bits sent.
REQ-030 start pulsed at cycle 4 of a transfer, pattern changed to 8'hFF -> original stream unaffected, no second transfer.
REQ-031 reset=0 at cycle 5 of an 8-bit transfer -> next cycle all outputs 0, present_state=2'b00, no done.
REQ-032 SEQGEN_REPEAT_EN, pattern=8'b1010_0110, len=4, repeat=1 for 3 passes -> 1,0,1,0 repeated 3x over 12 contiguous valid cycles, single done after pass 3.
REQ-033 Lock-step: serial_out/bit_valid feed the team's sequence detector with pattern 8'b0010_1011 -> detector indication matches the golden model every cycle.
